// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: IF/ID control codes and fetch FSM states.
package riscv_pkg;

  localparam logic [1:0] CTRL_LOAD  = 2'b00;
  localparam logic [1:0] CTRL_HOLD  = 2'b01;
  localparam logic [1:0] CTRL_FLUSH = 2'b11;

  // state   | meaning
  // IDLE    | first cycle out of reset, nothing in flight
  // REQ     | issuing a fetch at pc
  // WAIT    | one request outstanding, waiting for rvalid
  // HOLD    | fetched word parked in the buffer while decode stalls
  // DISCARD | stale request outstanding after a redirect, drop its response
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    HOLD    = 3'd3,
    DISCARD = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between fetch and imem.
interface fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_rvalid, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/fetch_buf.sv
// One-entry instruction buffer holding a word fetched while decode stalls.
module fetch_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] data_q;

  // Clear wins over load so a redirect always drops the parked word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       data_q <= '0;
    else if (clear_i) data_q <= '0;
    else if (load_i)  data_q <= data_i;
  end

  assign data_o = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, stall buffering, redirect flush.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    imem,
  input  logic            stall_i,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic [1:0]      if_ctrl
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            buf_load, buf_clear;
  logic [XLEN-1:0] buf_data;
  logic            in_flight;

  fetch_buf #(.XLEN(XLEN)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (imem.imem_rdata),
    .data_o  (buf_data)
  );

  // A request issued this cycle or still unanswered means a stale response will arrive.
  assign in_flight = (state_q == REQ) ||
                     ((state_q == WAIT || state_q == DISCARD) && !imem.imem_rvalid);

  // Next-state, pc update and IF/ID presentation; redirect > stall > valid word.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    if_instr  = buf_data;
    if_ctrl   = stall_i ? CTRL_HOLD : CTRL_FLUSH;
    if (redirect_valid) begin
      if_ctrl   = CTRL_FLUSH;
      pc_d      = redirect_pc & ~XLEN'(3);
      buf_clear = 1'b1;
      state_d   = in_flight ? DISCARD : REQ;
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ:  state_d = WAIT;
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (stall_i) begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end else begin
              if_ctrl  = CTRL_LOAD;
              if_instr = imem.imem_rdata;
              pc_d     = pc_q + XLEN'(4);
              state_d  = REQ;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            if_ctrl = CTRL_LOAD;
            pc_d    = pc_q + XLEN'(4);
            state_d = REQ;
          end
        end
        DISCARD: if (imem.imem_rvalid) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and program counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign if_pc          = pc_q;

endmodule
